decode_stage: RTL and testbench

Instruction decode stage directly upstream of the ALU. Accepts one 32-bit MIPS instruction per cycle over a valid/ready handshake, splits its fields, and reads both source operands from an internal 32x32 register file with a writeback port. It registers the ALU inputs (OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC, RAW_VAL) plus the destination index. The branch signal produced downstream by the ALU is used to flush this stage.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/reg_file.sv | 28 ++
 rtl/decode_stage.sv | 83 ++++++++
 tb/tb_decode_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS field positions, opcodes, widths and the decoded-instruction record
package mips_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int REG_CNT = 32;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam int OP_MSB  = 31, OP_LSB  = 26;
  localparam int RS_MSB  = 25, RS_LSB  = 21;
  localparam int RT_MSB  = 20, RT_LSB  = 16;
  localparam int RD_MSB  = 15, RD_LSB  = 11;
  localparam int SH_MSB  = 10, SH_LSB  = 6;
  localparam int FN_MSB  = 5,  FN_LSB  = 0;
  localparam int IMM_MSB = 15, IMM_LSB = 0;
  typedef struct packed {
    logic [5:0]        opcode;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [4:0]        shamt;
    logic [5:0]        func;
    logic [15:0]       raw_val;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0] rt_idx;
  } dec_t;
endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file; ports: clk, rst (async high), rs/rt combinational reads, wb write port, r0 hardwired to 0, write-to-read bypass
module reg_file
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);
  logic [DATA_W-1:0] mem_q [REG_CNT];
  logic [DATA_W-1:0] mem_d [REG_CNT];
  logic              we;
  assign we = wb_en && wb_addr != '0;
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wb_addr] = wb_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < REG_CNT; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
  assign rs_data = rs_addr == '0 ? '0 : (we && wb_addr == rs_addr) ? wb_data : mem_q[rs_addr];
  assign rt_data = rt_addr == '0 ? '0 : (we && wb_addr == rt_addr) ? wb_data : mem_q[rt_addr];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS decode; ports: CLK/RST(async high), INSTR valid/ready in, WB write port, FLUSH, registered ALU fields out with OUT_VALID/OUT_READY
module decode_stage
  import mips_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       INSTR,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic              WB_EN,
  input  logic [REG_AW-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [5:0]        OPCODE,
  output logic [DATA_W-1:0] RS_VAL,
  output logic [DATA_W-1:0] RT_VAL,
  output logic [4:0]        SHAMT,
  output logic [5:0]        FUNC,
  output logic [15:0]       RAW_VAL,
  output logic [REG_AW-1:0] DEST
);
  dec_t              dec_q, dec_d;
  logic              out_valid_q, out_valid_d;
  logic              accept, hold, wr;
  logic [5:0]        op;
  logic [REG_AW-1:0] rs_idx, rt_idx;
  logic [DATA_W-1:0] rs_data, rt_data;
  assign op     = INSTR[OP_MSB:OP_LSB];
  assign rs_idx = INSTR[RS_MSB:RS_LSB];
  assign rt_idx = INSTR[RT_MSB:RT_LSB];
  reg_file u_rf (
    .clk     (CLK),
    .rst     (RST),
    .rs_addr (rs_idx),
    .rt_addr (rt_idx),
    .wb_en   (WB_EN),
    .wb_addr (WB_ADDR),
    .wb_data (WB_DATA),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );
  assign INSTR_READY = !out_valid_q || OUT_READY || FLUSH;
  assign accept      = INSTR_VALID && INSTR_READY && !FLUSH;
  assign hold        = out_valid_q && !OUT_READY && !FLUSH;
  assign wr          = WB_EN && WB_ADDR != '0;
  // a held instruction tracks writes to its own source registers so it never leaves with stale operands
  always_comb begin
    dec_d       = dec_q;
    out_valid_d = !FLUSH && (accept || hold);
    if (accept) begin
      dec_d.opcode  = op;
      dec_d.rs_idx  = rs_idx;
      dec_d.rt_idx  = rt_idx;
      dec_d.rs_val  = rs_data;
      dec_d.rt_val  = rt_data;
      dec_d.shamt   = INSTR[SH_MSB:SH_LSB];
      dec_d.func    = INSTR[FN_MSB:FN_LSB];
      dec_d.raw_val = INSTR[IMM_MSB:IMM_LSB];
      dec_d.dest    = op == OP_RTYPE ? INSTR[RD_MSB:RD_LSB] : rt_idx;
    end else if (hold) begin
      dec_d.rs_val = (wr && WB_ADDR == dec_q.rs_idx) ? WB_DATA : dec_q.rs_val;
      dec_d.rt_val = (wr && WB_ADDR == dec_q.rt_idx) ? WB_DATA : dec_q.rt_val;
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      dec_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
    end
  assign OUT_VALID = out_valid_q;
  assign OPCODE    = dec_q.opcode;
  assign RS_VAL    = dec_q.rs_val;
  assign RT_VAL    = dec_q.rt_val;
  assign SHAMT     = dec_q.shamt;
  assign FUNC      = dec_q.func;
  assign RAW_VAL   = dec_q.raw_val;
  assign DEST      = dec_q.dest;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized check of decode_stage against a behavioural model
module tb_decode_stage;
  import mips_pkg::*;
  logic        CLK = 0, RST = 0;
  logic [31:0] INSTR = 0;
  logic        INSTR_VALID = 0, INSTR_READY;
  logic        WB_EN = 0;
  logic [4:0]  WB_ADDR = 0;
  logic [31:0] WB_DATA = 0;
  logic        FLUSH = 0, OUT_VALID, OUT_READY = 0;
  logic [5:0]  OPCODE, FUNC;
  logic [31:0] RS_VAL, RT_VAL;
  logic [4:0]  SHAMT, DEST;
  logic [15:0] RAW_VAL;
  int n_chk = 0, n_fail = 0;

  decode_stage dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OPCODE(OPCODE), .RS_VAL(RS_VAL),
    .RT_VAL(RT_VAL), .SHAMT(SHAMT), .FUNC(FUNC), .RAW_VAL(RAW_VAL), .DEST(DEST)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic        m_valid = 0;
  logic [5:0]  m_op = 0, m_fn = 0;
  logic [31:0] m_rs = 0, m_rt = 0;
  logic [4:0]  m_sh = 0, m_dest = 0, m_rsi = 0, m_rti = 0;
  logic [15:0] m_raw = 0;
  logic [31:0] m_regs [32];

  function automatic logic [31:0] rd(input logic [4:0] i);
    if (i == 0) return 0;
    if (WB_EN && WB_ADDR == i) return WB_DATA;
    return m_regs[i];
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_valid <= 0; m_op <= 0; m_fn <= 0; m_rs <= 0; m_rt <= 0;
      m_sh <= 0; m_dest <= 0; m_rsi <= 0; m_rti <= 0; m_raw <= 0;
      for (int i = 0; i < 32; i++) m_regs[i] <= 0;
    end else begin
      if (FLUSH) m_valid <= 0;
      else if (INSTR_VALID && (!m_valid || OUT_READY)) begin
        m_valid <= 1;
        m_op    <= INSTR[31:26];
        m_rsi   <= INSTR[25:21];
        m_rti   <= INSTR[20:16];
        m_rs    <= rd(INSTR[25:21]);
        m_rt    <= rd(INSTR[20:16]);
        m_sh    <= INSTR[10:6];
        m_fn    <= INSTR[5:0];
        m_raw   <= INSTR[15:0];
        m_dest  <= INSTR[31:26] == 0 ? INSTR[15:11] : INSTR[20:16];
      end else if (m_valid && !OUT_READY) begin
        if (WB_EN && WB_ADDR != 0 && WB_ADDR == m_rsi) m_rs <= WB_DATA;
        if (WB_EN && WB_ADDR != 0 && WB_ADDR == m_rti) m_rt <= WB_DATA;
      end else m_valid <= 0;
      if (WB_EN && WB_ADDR != 0) m_regs[WB_ADDR] <= WB_DATA;
    end
  end

  always @(negedge CLK) begin
    chk("instr_ready", INSTR_READY, !m_valid || OUT_READY || FLUSH);
    chk("out_valid", OUT_VALID, m_valid);
    if (m_valid) begin
      chk("opcode", OPCODE, m_op);
      chk("rs_val", RS_VAL, m_rs);
      chk("rt_val", RT_VAL, m_rt);
      chk("shamt", SHAMT, m_sh);
      chk("func", FUNC, m_fn);
      chk("raw_val", RAW_VAL, m_raw);
      chk("dest", DEST, m_dest);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    WB_EN = en; WB_ADDR = a; WB_DATA = d;
  endtask

  initial begin
    #1 RST = 1;
    #2;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_instr_ready", INSTR_READY, 1);
    chk("rst_fields", {OPCODE, SHAMT, FUNC, RAW_VAL, DEST}, 0);
    chk("rst_rs_rt", RS_VAL | RT_VAL, 0);
    step();
    RST = 0;
    OUT_READY = 1;
    // ADD r3,r1,r2 after r1=15, r2=12
    wb(1, 1, 15); step();
    wb(1, 2, 12); step();
    wb(0, 0, 0); INSTR = 32'h00221820; INSTR_VALID = 1; step();
    INSTR_VALID = 0;
    chk("add_valid", OUT_VALID, 1);
    chk("add_opcode", OPCODE, 0);
    chk("add_rs", RS_VAL, 15);
    chk("add_rt", RT_VAL, 12);
    chk("add_func", FUNC, FUNC_ADD);
    chk("add_dest", DEST, 3);
    step();
    chk("add_drained", OUT_VALID, 0);
    // bypass: write r5=23 in the accept cycle of an rs=5 instruction
    wb(1, 5, 23); INSTR = 32'h00A03020; INSTR_VALID = 1; step();
    chk("byp_rs", RS_VAL, 23);
    chk("byp_dest", DEST, 6);
    wb(0, 0, 0); INSTR = 32'h20A71234; step();
    chk("r5_later", RS_VAL, 23);
    chk("itype_op", OPCODE, 6'h08);
    chk("itype_dest", DEST, 7);
    chk("itype_raw", RAW_VAL, 16'h1234);
    // zero register ignores writes
    wb(1, 0, 32'hFFFFFFFF); INSTR = 32'h00000020; step();
    wb(0, 0, 0); INSTR = 32'h00000020; step();
    chk("zero_rs", RS_VAL, 0);
    chk("zero_rt", RT_VAL, 0);
    // stall refresh on rt=2
    INSTR = 32'h00022020; step();
    INSTR_VALID = 0; OUT_READY = 0; wb(1, 2, 35); #1;
    chk("stall_ready_pre", INSTR_READY, 0);
    step();
    wb(0, 0, 0);
    chk("stall_rt", RT_VAL, 35);
    chk("stall_valid", OUT_VALID, 1);
    chk("stall_ready", INSTR_READY, 0);
    // flush with a colliding incoming instruction
    FLUSH = 1; INSTR_VALID = 1; INSTR = 32'h20A7BEEF; #1;
    chk("flush_ready", INSTR_READY, 1);
    step();
    FLUSH = 0; INSTR_VALID = 0;
    chk("flush_valid", OUT_VALID, 0);
    step();
    chk("flush_dropped", OUT_VALID, 0);
    // reset in the middle of a stream
    OUT_READY = 1; INSTR_VALID = 1;
    INSTR = 32'h00221820; step();
    INSTR = 32'h00A03020; step();
    INSTR = 32'h20A71234; step();
    INSTR_VALID = 0;
    #1 RST = 1;
    #1;
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_fields", {OPCODE, SHAMT, FUNC, RAW_VAL, DEST}, 0);
    chk("mid_rst_rs_rt", RS_VAL | RT_VAL, 0);
    RST = 0;
    INSTR = 32'h00200020; INSTR_VALID = 1; step();
    INSTR_VALID = 0;
    chk("r1_after_rst", RS_VAL, 0);
    // randomized traffic with small register indices to force collisions
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] w;
      w = $urandom;
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) w[31:26] = 0;
      INSTR = w;
      INSTR_VALID = $urandom_range(0, 9) < 7;
      OUT_READY = $urandom_range(0, 9) < 6;
      FLUSH = $urandom_range(0, 9) == 0;
      wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    INSTR_VALID = 0; FLUSH = 0; wb(0, 0, 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
